// File: rtl/uart_rx_sampler.sv
// Oversampling 8N1 UART receive front end: synchronizes rxd, validates the start bit,
// samples each bit mid-period and presents bytes on a one-entry valid/ready holding register.
module uart_rx_sampler #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic                 PCLK,
    input  logic                 PRESETn,
    input  logic                 os_tick,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);

    localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [1:0]           r_sync;
    logic                 w_rxs;
    logic [TW-1:0]        r_tick_cnt;
    logic [TW-1:0]        w_tick_cnt_next;
    logic [BW-1:0]        r_bit_cnt;
    logic [BW-1:0]        w_bit_cnt_next;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] w_shift_next;
    logic                 w_stop_ok;
    logic                 w_stop_bad;
    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_rx_valid;
    logic                 r_frame_err;
    logic                 r_overrun;
    logic                 r_busy;

    // Two-flop synchronizer; both stages reset to the idle (high) line level.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], rxd};
        end
    end

    assign w_rxs = r_sync[1];

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state    <= S_IDLE;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_tick_cnt <= w_tick_cnt_next;
            r_bit_cnt  <= w_bit_cnt_next;
            r_shift    <= w_shift_next;
            r_busy     <= (w_state_next != S_IDLE);
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_tick_cnt_next = r_tick_cnt;
        w_bit_cnt_next  = r_bit_cnt;
        w_shift_next    = r_shift;
        w_stop_ok       = 1'b0;
        w_stop_bad      = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (os_tick && !w_rxs) begin
                    w_state_next    = S_START;
                    w_tick_cnt_next = '0;
                end
            end

            // Half a bit period after the falling edge: a high line means a glitch.
            S_START: begin
                if (os_tick) begin
                    if (r_tick_cnt == HALF_LAST) begin
                        if (w_rxs) begin
                            w_state_next = S_IDLE;
                        end else begin
                            w_state_next    = S_DATA;
                            w_tick_cnt_next = '0;
                            w_bit_cnt_next  = '0;
                        end
                    end else begin
                        w_tick_cnt_next = r_tick_cnt + TW'(1);
                    end
                end
            end

            S_DATA: begin
                if (os_tick) begin
                    if (r_tick_cnt == FULL_LAST) begin
                        w_tick_cnt_next = '0;
                        w_shift_next    = {w_rxs, r_shift[DATA_BITS-1:1]};
                        w_bit_cnt_next  = r_bit_cnt + BW'(1);
                        if (r_bit_cnt == BIT_LAST) begin
                            w_state_next = S_STOP;
                        end
                    end else begin
                        w_tick_cnt_next = r_tick_cnt + TW'(1);
                    end
                end
            end

            // Return to IDLE straight after the stop sample; a still-low line restarts.
            S_STOP: begin
                if (os_tick) begin
                    if (r_tick_cnt == FULL_LAST) begin
                        w_state_next    = S_IDLE;
                        w_tick_cnt_next = '0;
                        w_bit_cnt_next  = '0;
                        w_stop_ok       = w_rxs;
                        w_stop_bad      = !w_rxs;
                    end else begin
                        w_tick_cnt_next = r_tick_cnt + TW'(1);
                    end
                end
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Holding register: a completing frame may refill on the same edge it is drained.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= w_stop_bad;
            r_overrun   <= 1'b0;
            if (w_stop_ok) begin
                if (!r_rx_valid || rx_ready) begin
                    r_rx_data  <= r_shift;
                    r_rx_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_rx_valid && rx_ready) begin
                r_rx_valid <= 1'b0;
            end
        end
    end

    assign rx_data   = r_rx_data;
    assign rx_valid  = r_rx_valid;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;
    assign busy      = r_busy;

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Directed plus randomized frames against a frame-level model of the receiver's
// holding register, flag pulses and sampling-point timing.
module tb_uart_rx_sampler;

    logic       PCLK     = 1'b0;
    logic       PRESETn  = 1'b0;
    logic       os_tick  = 1'b0;
    logic       rxd      = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    uart_rx_sampler #(
        .OVERSAMPLE (16),
        .DATA_BITS  (8)
    ) dut (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .os_tick   (os_tick),
        .rxd       (rxd),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 PCLK = ~PCLK;

    int n_cmp = 0;
    int n_err = 0;

    // Tick bookkeeping and event capture
    int   tick_no        = 0;
    int   fe_cnt         = 0;
    int   ov_cnt         = 0;
    int   fe_tick        = -1;
    int   ov_tick        = -1;
    int   rise_tick      = -1;
    int   busy_rise_tick = -1;
    int   busy_fall_tick = -1;
    logic prev_valid     = 1'b0;
    logic prev_busy      = 1'b0;

    // Frame-level reference model
    logic       exp_valid = 1'b0;
    logic [7:0] exp_data  = 8'h00;
    int         exp_fe    = 0;
    int         exp_ov    = 0;

    always @(negedge PCLK) begin
        if (frame_err) begin
            fe_cnt++;
            fe_tick = tick_no;
        end
        if (overrun) begin
            ov_cnt++;
            ov_tick = tick_no;
        end
        if (rx_valid && !prev_valid) rise_tick = tick_no;
        if (busy && !prev_busy) busy_rise_tick = tick_no;
        if (!busy && prev_busy && busy_fall_tick < 0) busy_fall_tick = tick_no;
        prev_valid = rx_valid;
        prev_busy  = busy;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One oversampling tick: line settles through the synchronizer before the pulse.
    task automatic tick_step(input logic line, input logic rdy);
        rxd = line;
        repeat (3) @(negedge PCLK);
        os_tick  = 1'b1;
        rx_ready = rdy;
        tick_no++;
        @(negedge PCLK);
        os_tick  = 1'b0;
        rx_ready = 1'b0;
    endtask

    task automatic idle_ticks(input int n);
        for (int k = 0; k < n; k++) tick_step(1'b1, 1'b0);
    endtask

    task automatic drain(input string tag);
        rx_ready = 1'b1;
        @(negedge PCLK);
        rx_ready  = 1'b0;
        exp_valid = 1'b0;
        chk({tag, ":drain_valid"}, 32'(rx_valid), 32'(exp_valid));
    endtask

    task automatic run_frame(input string tag, input logic [7:0] b, input logic stop,
                             input logic rdy_end);
        int   t0;
        logic was_valid;
        logic line;
        logic loaded;
        was_valid      = exp_valid;
        loaded         = 1'b0;
        rise_tick      = -1;
        busy_fall_tick = -1;
        t0             = tick_no + 1;
        for (int k = 0; k < 160; k++) begin
            if (k < 16)       line = 1'b0;
            else if (k < 144) line = b[k/16-1];
            else              line = stop;
            tick_step(line, rdy_end && (k == 152));
        end
        if (!stop) begin
            exp_fe++;
            if (rdy_end) exp_valid = 1'b0;
        end else if (!exp_valid || rdy_end) begin
            exp_data  = b;
            exp_valid = 1'b1;
            loaded    = 1'b1;
        end else begin
            exp_ov++;
        end
        $display("frame %s byte=%02h stop=%0d rdy=%0d -> valid=%0d data=%02h fe=%0d ov=%0d",
                 tag, b, stop, rdy_end, rx_valid, rx_data, fe_cnt, ov_cnt);
        chk({tag, ":valid"}, 32'(rx_valid), 32'(exp_valid));
        chk({tag, ":data"}, 32'(rx_data), 32'(exp_data));
        chk({tag, ":fe_count"}, fe_cnt, exp_fe);
        chk({tag, ":ov_count"}, ov_cnt, exp_ov);
        chk({tag, ":busy_fall_tick"}, busy_fall_tick, t0 + 152);
        if (!stop) chk({tag, ":fe_tick"}, fe_tick, t0 + 152);
        if (stop && was_valid && !rdy_end) chk({tag, ":ov_tick"}, ov_tick, t0 + 152);
        if (loaded && !was_valid) chk({tag, ":valid_rise_tick"}, rise_tick, t0 + 152);
    endtask

    initial begin
        int   t0;
        logic [7:0] rb;
        logic       rs;
        logic       rr;

        repeat (3) @(negedge PCLK);
        chk("reset:valid", 32'(rx_valid), 32'd0);
        chk("reset:data", 32'(rx_data), 32'd0);
        chk("reset:busy", 32'(busy), 32'd0);
        chk("reset:frame_err", 32'(frame_err), 32'd0);
        chk("reset:overrun", 32'(overrun), 32'd0);
        PRESETn = 1'b1;
        @(negedge PCLK);
        idle_ticks(4);

        // Ideal frame, consumer not ready
        run_frame("a5", 8'hA5, 1'b1, 1'b0);
        drain("a5");
        idle_ticks(3);

        // Short low glitch: START entered, abandoned at T0+8
        busy_rise_tick = -1;
        busy_fall_tick = -1;
        t0 = tick_no + 1;
        for (int k = 0; k < 4; k++) tick_step(1'b0, 1'b0);
        idle_ticks(12);
        $display("glitch busy rise=%0d fall=%0d (T0=%0d)", busy_rise_tick, busy_fall_tick, t0);
        chk("glitch:busy_rise", busy_rise_tick, t0);
        chk("glitch:busy_fall", busy_fall_tick, t0 + 8);
        chk("glitch:valid", 32'(rx_valid), 32'(exp_valid));
        chk("glitch:fe_count", fe_cnt, exp_fe);
        chk("glitch:ov_count", ov_cnt, exp_ov);

        // Framing error, then a clean frame
        run_frame("3c_badstop", 8'h3C, 1'b0, 1'b0);
        idle_ticks(4);
        run_frame("11", 8'h11, 1'b1, 1'b0);
        drain("11");
        idle_ticks(2);

        // Back-to-back without draining: second frame overruns
        run_frame("01a", 8'h01, 1'b1, 1'b0);
        run_frame("02a", 8'h02, 1'b1, 1'b0);
        drain("02a");
        idle_ticks(2);

        // Back-to-back with ready on the completion edge of the second frame
        run_frame("01b", 8'h01, 1'b1, 1'b0);
        run_frame("02b", 8'h02, 1'b1, 1'b1);

        // Reset in the middle of data bit 4 of 0xFF, with a byte still held
        t0 = tick_no + 1;
        for (int k = 0; k < 89; k++) tick_step((k < 16) ? 1'b0 : 1'b1, 1'b0);
        PRESETn = 1'b0;
        #1;
        exp_valid = 1'b0;
        exp_data  = 8'h00;
        $display("reset mid-frame valid=%0d data=%02h busy=%0d", rx_valid, rx_data, busy);
        chk("midrst:valid", 32'(rx_valid), 32'(exp_valid));
        chk("midrst:data", 32'(rx_data), 32'(exp_data));
        chk("midrst:busy", 32'(busy), 32'd0);
        chk("midrst:frame_err", 32'(frame_err), 32'd0);
        chk("midrst:overrun", 32'(overrun), 32'd0);
        repeat (3) @(negedge PCLK);
        PRESETn = 1'b1;
        @(negedge PCLK);
        idle_ticks(4);
        run_frame("5a", 8'h5A, 1'b1, 1'b0);
        drain("5a");
        idle_ticks(2);

        // Randomized frames
        for (int i = 0; i < 8; i++) begin
            rb = 8'($urandom_range(0, 255));
            rs = ($urandom_range(0, 3) != 0);
            rr = 1'($urandom_range(0, 1));
            run_frame($sformatf("rnd%0d", i), rb, rs, rr);
            if ($urandom_range(0, 2) == 0) drain($sformatf("rnd%0d", i));
            if (rs) idle_ticks(int'($urandom_range(0, 3)));
            else    idle_ticks(int'($urandom_range(2, 6)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
